// File: rtl/generic_fifo_sc_ctrl_pkg.sv
// Shared defaults and helpers for the single-clock FIFO controller.
package generic_fifo_sc_ctrl_pkg;

   localparam int unsigned AW_DEFAULT = 4;
   localparam int unsigned DW_DEFAULT = 8;
   localparam int unsigned N_DEFAULT  = 2;

   // Number of entries addressed by an aw-bit pointer.
   function automatic int unsigned fifo_depth(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

endpackage

// File: rtl/generic_dpram.sv
// Generic synchronous dual-port RAM: registered read address, write on wclk.
// Read data is taken from the array through the registered address, so a
// write to the addressed word is visible right after the write edge.
module generic_dpram #(
   parameter int unsigned aw = 4,
   parameter int unsigned dw = 8
) (
   input  logic          rclk,
   input  logic          rrst,
   input  logic          rce,
   input  logic          oe,
   input  logic [aw-1:0] raddr,
   output logic [dw-1:0] dout,
   input  logic          wclk,
   input  logic          wrst,
   input  logic          wce,
   input  logic          we,
   input  logic [aw-1:0] waddr,
   input  logic [dw-1:0] di
);

   localparam int unsigned DEPTH = 32'd1 << aw;

   logic [dw-1:0] mem [0:DEPTH-1];
   logic [aw-1:0] ra;

   // Read address register.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) ra <= '0;
      else if (rce) ra <= raddr;
   end

   // Write port; storage is never reset, writes are blocked while wrst is high.
   always_ff @(posedge wclk) begin
      if (wce && we && !wrst) mem[waddr] <= di;
   end

   assign dout = oe ? mem[ra] : '0;

endmodule

// File: rtl/generic_fifo_sc_ctrl.sv
// Single-clock first-word-fall-through FIFO controller around generic_dpram.
// Optional sticky overflow/underflow detection: define FIFO_ERR_FLAG_EN.
module generic_fifo_sc_ctrl
   import generic_fifo_sc_ctrl_pkg::*;
#(
   parameter int unsigned aw = AW_DEFAULT,
   parameter int unsigned dw = DW_DEFAULT,
   parameter int unsigned n  = N_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [dw-1:0] din,
   input  logic          we,
   input  logic          re,
   output logic [dw-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic          full_n,
   output logic          empty_n,
   output logic [aw:0]   level,
   output logic          ovf,
   output logic          udf
);

   localparam int unsigned CW    = aw + 1;
   localparam int unsigned DEPTH = fifo_depth(aw);

   logic [aw-1:0] wp;
   logic [aw-1:0] rp;
   logic [aw-1:0] rp_next;
   logic [aw-1:0] raddr;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          wr_ok;
   logic          rd_ok;

   assign wr_ok   = we & ~full;
   assign rd_ok   = re & ~empty;
   assign rp_next = rp + aw'(rd_ok);
   // On clr the read pointer returns to 0, so the RAM address must follow.
   assign raddr   = clr ? '0 : rp_next;
   assign level   = cnt;

   // Next occupancy from accepted writes and reads.
   always_comb begin
      cnt_next = cnt;
      case ({wr_ok, rd_ok})
         2'b10:   cnt_next = cnt + CW'(1);
         2'b01:   cnt_next = cnt - CW'(1);
         default: cnt_next = cnt;
      endcase
   end

   // Pointers, count and flags; flags derive from cnt_next to avoid lag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp      <= '0;
         rp      <= '0;
         cnt     <= '0;
         full    <= 1'b0;
         empty   <= 1'b1;
         full_n  <= 1'b0;
         empty_n <= 1'b1;
      end else if (clr) begin
         wp      <= '0;
         rp      <= '0;
         cnt     <= '0;
         full    <= 1'b0;
         empty   <= 1'b1;
         full_n  <= 1'b0;
         empty_n <= 1'b1;
      end else begin
         wp      <= wp + aw'(wr_ok);
         rp      <= rp_next;
         cnt     <= cnt_next;
         full    <= (cnt_next == CW'(DEPTH));
         empty   <= (cnt_next == '0);
         full_n  <= (cnt_next >= CW'(DEPTH - n));
         empty_n <= (cnt_next <= CW'(n));
      end
   end

`ifdef FIFO_ERR_FLAG_EN
   // Sticky error flags: push while full, pop while empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else if (clr) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (we && full)  ovf <= 1'b1;
         if (re && empty) udf <= 1'b1;
      end
   end
`else
   assign ovf = 1'b0;
   assign udf = 1'b0;
`endif

   generic_dpram #(
      .aw (aw),
      .dw (dw)
   ) u_ram (
      .rclk  (clk),
      .rrst  (rst),
      .rce   (1'b1),
      .oe    (1'b1),
      .raddr (raddr),
      .dout  (dout),
      .wclk  (clk),
      .wrst  (rst),
      .wce   (1'b1),
      .we    (wr_ok & ~clr),
      .waddr (wp),
      .di    (din)
   );

endmodule

// File: tb/tb_generic_fifo_sc_ctrl.sv
// Directed bench for generic_fifo_sc_ctrl (aw=4, dw=8, n=2).
module tb_generic_fifo_sc_ctrl;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned N  = 2;

`ifdef FIFO_ERR_FLAG_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          clr;
   logic [DW-1:0] din;
   logic          we;
   logic          re;
   logic [DW-1:0] dout;
   logic          full;
   logic          empty;
   logic          full_n;
   logic          empty_n;
   logic [AW:0]   level;
   logic          ovf;
   logic          udf;

   int tests_run    = 0;
   int tests_failed = 0;

   generic_fifo_sc_ctrl #(.aw(AW), .dw(DW), .n(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .din     (din),
      .we      (we),
      .re      (re),
      .dout    (dout),
      .full    (full),
      .empty   (empty),
      .full_n  (full_n),
      .empty_n (empty_n),
      .level   (level),
      .ovf     (ovf),
      .udf     (udf)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      we = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din = 8'(8'h50 + i);
         tick();
      end
      we = 1'b0;
      tests_run++;
      if (level !== 5'd3) begin
         tests_failed++;
         $display("FAIL reset_pre_level: got %0d expected 3", level);
      end
      #3;
      rst = 1'b1;
      #1;
      tests_run++;
      if ({empty, full, full_n, empty_n} !== 4'b1001) begin
         tests_failed++;
         $display("FAIL reset_flags: got e/f/fn/en=%b expected 1001", {empty, full, full_n, empty_n});
      end
      tests_run++;
      if (level !== 5'd0) begin
         tests_failed++;
         $display("FAIL reset_level: got %0d expected 0", level);
      end
      tests_run++;
      if ({ovf, udf} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_err: got ovf/udf=%b expected 00", {ovf, udf});
      end
      #1;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fill;
      we = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         din = 8'(i);
         tick();
         tests_run++;
         if (level !== 5'(i) || full_n !== (i >= 14) || full !== (i == 16) || empty_n !== (i <= 2)) begin
            tests_failed++;
            $display("FAIL fill_%0d: got level=%0d fn=%b f=%b en=%b expected level=%0d fn=%b f=%b en=%b",
                     i, level, full_n, full, empty_n, i, (i >= 14), (i == 16), (i <= 2));
         end
      end
      tests_run++;
      if (dout !== 8'h01 || ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL fill_head: got dout=%h ovf=%b expected dout=01 ovf=0", dout, ovf);
      end
      din = 8'hFF;
      tick();
      we = 1'b0;
      tests_run++;
      if (level !== 5'd16 || full !== 1'b1 || ovf !== ERR_EN) begin
         tests_failed++;
         $display("FAIL overflow: got level=%0d full=%b ovf=%b expected level=16 full=1 ovf=%b",
                  level, full, ovf, ERR_EN);
      end
   endtask

   task automatic test_full_simul;
      we  = 1'b1;
      re  = 1'b1;
      din = 8'h77;
      tick();
      we  = 1'b0;
      re  = 1'b0;
      tests_run++;
      if (level !== 5'd15 || dout !== 8'h02 || full !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_simul: got level=%0d dout=%h full=%b expected level=15 dout=02 full=0",
                  level, dout, full);
      end
      re = 1'b1;
      for (int i = 2; i <= 16; i++) begin
         tests_run++;
         if (dout !== 8'(i)) begin
            tests_failed++;
            $display("FAIL drain_%0d: got dout=%h expected %h", i, dout, 8'(i));
         end
         tick();
      end
      re = 1'b0;
      tests_run++;
      if (empty !== 1'b1 || level !== 5'd0 || udf !== 1'b0) begin
         tests_failed++;
         $display("FAIL drain_end: got empty=%b level=%0d udf=%b expected 1 0 0", empty, level, udf);
      end
   endtask

   task automatic test_single_word;
      we  = 1'b1;
      din = 8'hA5;
      tick();
      we  = 1'b0;
      tests_run++;
      if (dout !== 8'hA5 || empty !== 1'b0 || level !== 5'd1) begin
         tests_failed++;
         $display("FAIL single_write: got dout=%h empty=%b level=%0d expected A5 0 1", dout, empty, level);
      end
      re = 1'b1;
      tick();
      tests_run++;
      if (empty !== 1'b1 || level !== 5'd0 || udf !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_pop: got empty=%b level=%0d udf=%b expected 1 0 0", empty, level, udf);
      end
      tick();
      re = 1'b0;
      tests_run++;
      if (level !== 5'd0 || empty !== 1'b1 || udf !== ERR_EN) begin
         tests_failed++;
         $display("FAIL underflow: got level=%0d empty=%b udf=%b expected 0 1 %b", level, empty, udf, ERR_EN);
      end
   endtask

   task automatic test_empty_simul;
      we  = 1'b1;
      re  = 1'b1;
      din = 8'h3C;
      tick();
      we  = 1'b0;
      re  = 1'b0;
      tests_run++;
      if (level !== 5'd1 || dout !== 8'h3C || empty !== 1'b0) begin
         tests_failed++;
         $display("FAIL empty_simul: got level=%0d dout=%h empty=%b expected 1 3C 0", level, dout, empty);
      end
      re = 1'b1;
      tick();
      re = 1'b0;
   endtask

   task automatic test_wrap;
      logic [DW-1:0] q[$];
      logic [DW-1:0] next_data = 8'h80;
      for (int i = 0; i < 40; i++) begin
         we  = (q.size() < 5) && (i % 4 != 3);
         re  = (q.size() > 1) && (i % 3 != 0);
         din = next_data;
         if (q.size() > 0) begin
            tests_run++;
            if (dout !== q[0]) begin
               tests_failed++;
               $display("FAIL wrap_dout_%0d: got %h expected %h", i, dout, q[0]);
            end
         end
         tick();
         if (re) void'(q.pop_front());
         if (we) begin
            q.push_back(next_data);
            next_data = next_data + 8'd1;
         end
         tests_run++;
         if (level !== 5'(q.size()) || empty_n !== (q.size() <= 2)) begin
            tests_failed++;
            $display("FAIL wrap_level_%0d: got level=%0d en=%b expected level=%0d en=%b",
                     i, level, empty_n, q.size(), (q.size() <= 2));
         end
      end
      we = 1'b0;
      re = 1'b1;
      while (q.size() > 0) begin
         tests_run++;
         if (dout !== q[0]) begin
            tests_failed++;
            $display("FAIL wrap_tail: got %h expected %h", dout, q[0]);
         end
         tick();
         void'(q.pop_front());
      end
      re = 1'b0;
   endtask

   task automatic test_clr;
      we = 1'b1;
      for (int i = 0; i < 7; i++) begin
         din = 8'(8'h60 + i);
         tick();
      end
      tests_run++;
      if (level !== 5'd7) begin
         tests_failed++;
         $display("FAIL clr_pre: got level=%0d expected 7", level);
      end
      clr = 1'b1;
      din = 8'h99;
      tick();
      clr = 1'b0;
      we  = 1'b0;
      tests_run++;
      if (level !== 5'd0 || {empty, full, full_n, empty_n} !== 4'b1001 || {ovf, udf} !== 2'b00) begin
         tests_failed++;
         $display("FAIL clr: got level=%0d e/f/fn/en=%b ovf/udf=%b expected 0 1001 00",
                  level, {empty, full, full_n, empty_n}, {ovf, udf});
      end
      tick();
      tests_run++;
      if (empty !== 1'b1 || level !== 5'd0) begin
         tests_failed++;
         $display("FAIL clr_discard: got empty=%b level=%0d expected 1 0", empty, level);
      end
      we  = 1'b1;
      din = 8'h42;
      tick();
      we  = 1'b0;
      tests_run++;
      if (dout !== 8'h42 || level !== 5'd1) begin
         tests_failed++;
         $display("FAIL clr_after: got dout=%h level=%0d expected 42 1", dout, level);
      end
   endtask

   initial begin
      rst = 1'b1;
      clr = 1'b0;
      din = '0;
      we  = 1'b0;
      re  = 1'b0;
      #12;
      rst = 1'b0;
      tick();
      test_reset();
      test_fill();
      test_full_simul();
      test_single_word();
      test_empty_simul();
      test_wrap();
      test_clr();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
